// File: rtl/fetch_seq_pkg.sv
// fetch_seq_pkg: state encoding and shared constants for the fetch sequencer.
// Also holds the watchdog width helper used when FETCH_SEQ_TIMEOUT_EN is set.
package fetch_seq_pkg;

   localparam int STATE_W = 3;
   localparam int INSTR_W = 32;
   localparam logic [31:0] DEF_RESET_PC = 32'd0;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_HALTED = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   // Counter must hold TIMEOUT_CYC-1; never narrower than 8 or wider than 32.
   function automatic int wdog_width(input int lim);
      int w;
      w = $clog2(lim + 1);
      if (w < 8) w = 8;
      if (w > 32) w = 32;
      return w;
   endfunction

endpackage

// File: rtl/fetch_seq_wdog.sv
// fetch_seq_wdog: counts FETCH cycles without an ack.
// expire is high in the FETCH cycle that would reach LIMIT.
module fetch_seq_wdog #(
   parameter int LIMIT = 255,
   parameter int CNT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expire
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expire = inc && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: PC owner and fetch/commit sequencer with run/halt/step control.
// Define FETCH_SEQ_TIMEOUT_EN to add the fetch watchdog and ERROR state.
module fetch_seq
   import fetch_seq_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
   parameter int                TIMEOUT_CYC = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               halt_req,
   input  logic               step_req,
   input  logic [ADDR_W-1:0]  last_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic [31:0]        retired,
   output logic [STATE_W-1:0] state,
   output logic               done,
   output logic               err
);

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   pc_q;
   logic [INSTR_W-1:0]  instr_q;
   logic [31:0]         retired_q;
   logic                step_q;

   logic                ld_instr;
   logic                commit;
   logic                pc_inc;
   logic                restart;
   logic                step_set;
   logic                step_clr;
   logic                tmo_hit;

`ifdef FETCH_SEQ_TIMEOUT_EN
   fetch_seq_wdog #(
      .LIMIT (TIMEOUT_CYC),
      .CNT_W (wdog_width(TIMEOUT_CYC))
   ) u_wdog (
      .clk    (clk),
      .rst    (rst),
      .clr    (state_q != S_FETCH),
      .inc    ((state_q == S_FETCH) && !imem_ack),
      .expire (tmo_hit)
   );

   assign err = (state_q == S_ERROR);
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;

   assign tmo_hit = 1'b0;
   assign err     = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      ld_instr = 1'b0;
      commit   = 1'b0;
      pc_inc   = 1'b0;
      restart  = 1'b0;
      step_set = 1'b0;
      step_clr = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_FETCH;
               step_clr = 1'b1;
            end
         end
         S_FETCH: begin
            if (imem_ack) begin
               ld_instr = 1'b1;
               state_d  = S_EXEC;
            end else if (tmo_hit) begin
               state_d = S_ERROR;
            end
         end
         S_EXEC: begin
            commit = 1'b1;
            if (pc_q == last_pc) begin
               state_d = S_DONE;
            end else begin
               pc_inc  = 1'b1;
               state_d = (halt_req || step_q) ? S_HALTED : S_FETCH;
            end
         end
         S_HALTED: begin
            // step_req outranks start when both arrive together
            if (step_req) begin
               state_d  = S_FETCH;
               step_set = 1'b1;
            end else if (start) begin
               state_d  = S_FETCH;
               step_clr = 1'b1;
            end
         end
         S_DONE: begin
            if (start) begin
               state_d  = S_FETCH;
               restart  = 1'b1;
               step_clr = 1'b1;
            end
         end
         S_ERROR: begin
            state_d = S_ERROR;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         instr_q   <= '0;
         retired_q <= '0;
         step_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (ld_instr) begin
            instr_q <= imem_rdata;
         end
         if (restart) begin
            pc_q      <= RESET_PC;
            retired_q <= '0;
         end else begin
            if (pc_inc) begin
               pc_q <= pc_q + 1'b1;
            end
            if (commit) begin
               retired_q <= retired_q + 1'b1;
            end
         end
         if (step_set) begin
            step_q <= 1'b1;
         end else if (step_clr) begin
            step_q <= 1'b0;
         end
      end
   end

   assign imem_req    = (state_q == S_FETCH);
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign instr_valid = (state_q == S_EXEC);
   assign pc          = pc_q;
   assign retired     = retired_q;
   assign state       = state_q;
   assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: memory model with per-address latency and a commit scoreboard.
// Table of free-run vectors plus hand sequences for delay, halt/step, reset, timeout.
module tb_fetch_seq;
   import fetch_seq_pkg::*;

   localparam int AW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          halt_req = 1'b0;
   logic          step_req = 1'b0;
   logic [AW-1:0] last_pc = '0;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic          imem_ack = 1'b0;
   logic [31:0]   imem_rdata = '0;
   logic [31:0]   instr;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic [31:0]   retired;
   logic [2:0]    state;
   logic          done;
   logic          err;

   fetch_seq #(
      .ADDR_W      (AW),
      .RESET_PC    ('0),
      .TIMEOUT_CYC (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .halt_req    (halt_req),
      .step_req    (step_req),
      .last_pc     (last_pc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .pc          (pc),
      .retired     (retired),
      .state       (state),
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } exp_t;

   exp_t          sb[$];
   bit            mem_en = 1'b1;
   int            lat_def = 0;
   logic [AW-1:0] slow_addr = '1;
   int            slow_lat = 0;
   int            slow_req_cyc = 0;
   logic [AW-1:0] exp_addr = '0;
   int            wcnt = 0;
   int            req_cyc = 0;
   int            n_commits = 0;

   function automatic logic [31:0] mem_data(input logic [AW-1:0] a);
      return 32'hC0DE_0000 ^ (a * 32'h0001_0003);
   endfunction

   // Memory model: ack after lat wait cycles; push expected commit on ack.
   always @(negedge clk) begin
      int lat;
      if (mem_en) begin
         imem_ack = 1'b0;
         if (imem_req && !rst) begin
            req_cyc++;
            lat = (imem_addr == slow_addr) ? slow_lat : lat_def;
            if (wcnt >= lat) begin
               chk("fetch_addr", imem_addr, exp_addr);
               imem_ack   = 1'b1;
               imem_rdata = mem_data(exp_addr);
               sb.push_back('{exp_addr, mem_data(exp_addr)});
               if (exp_addr == slow_addr) slow_req_cyc = req_cyc;
               exp_addr++;
               wcnt    = 0;
               req_cyc = 0;
            end else begin
               wcnt++;
            end
         end else begin
            wcnt    = 0;
            req_cyc = 0;
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (instr_valid) begin
         n_commits++;
         if (sb.size() == 0) begin
            chk("unexpected_commit", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("commit_instr", instr, e.data);
            chk("commit_pc", pc, e.addr);
         end
      end
   end

   task automatic do_reset();
      rst      = 1'b1;
      start    = 1'b0;
      halt_req = 1'b0;
      step_req = 1'b0;
      mem_en   = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      exp_addr  = '0;
      n_commits = 0;
   endtask

   task automatic run_to_done(output int cyc);
      cyc = 0;
      start = 1'b1;
      do begin
         @(posedge clk);
         #1;
         start = 1'b0;
         cyc++;
      end while (!done && cyc < 400);
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic wait_halted();
      int n;
      n = 0;
      while (state != 3'(S_HALTED) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (state != 3'(S_HALTED)) chk("halted_timeout", 0, 1);
   endtask

   task automatic wait_req_at(input logic [AW-1:0] a);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(imem_req && imem_addr == a) && n < 200);
      if (!(imem_req && imem_addr == a)) chk("req_wait_timeout", 0, 1);
   endtask

   task automatic wait_commit();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!instr_valid && n < 200);
      if (!instr_valid) chk("commit_wait_timeout", 0, 1);
   endtask

   typedef struct {
      logic [AW-1:0] lpc;
      int            lat;
      int            exp_ret;
      logic [AW-1:0] exp_pc;
      int            exp_cyc;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int cyc;
      int saved;

      // cycles to DONE from the start edge: 1 + N*(lat+2)
      vecs[0] = '{32'd3, 0, 4, 32'd3, 9};
      vecs[1] = '{32'd0, 0, 1, 32'd0, 3};
      vecs[2] = '{32'd2, 1, 3, 32'd2, 10};
      vecs[3] = '{32'd1, 3, 2, 32'd1, 11};
      vecs[4] = '{32'd5, 2, 6, 32'd5, 25};

      do_reset();
      chk("rst_state", state, 0);
      chk("rst_pc", pc, 0);
      chk("rst_instr", instr, 0);
      chk("rst_retired", retired, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      halt_req = 1'b1;
      step_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_ignores_halt_step", state, 0);
      halt_req = 1'b0;
      step_req = 1'b0;

      foreach (vecs[i]) begin
         do_reset();
         last_pc = vecs[i].lpc;
         lat_def = vecs[i].lat;
         run_to_done(cyc);
         chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
         chk($sformatf("v%0d_retired", i), retired, vecs[i].exp_ret);
         chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
         chk($sformatf("v%0d_commits", i), n_commits, vecs[i].exp_ret);
         chk($sformatf("v%0d_state", i), state, 4);
      end
      lat_def = 0;

      // last_pc == RESET_PC, then restart from DONE
      do_reset();
      last_pc = '0;
      run_to_done(cyc);
      chk("single_retired", retired, 1);
      exp_addr = '0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("restart_state", state, 1);
      chk("restart_retired", retired, 0);
      chk("restart_pc", pc, 0);
      run_to_done(cyc);
      chk("restart_done_retired", retired, 1);
      chk("restart_commits", n_commits, 2);

      // ack delayed 5 cycles on addr 1
      do_reset();
      last_pc   = 32'd3;
      slow_addr = 32'd1;
      slow_lat  = 5;
      run_to_done(cyc);
      chk("slow_req_cycles", slow_req_cyc, 6);
      chk("slow_total_cycles", cyc, 14);
      chk("slow_retired", retired, 4);
      chk("slow_commits", n_commits, 4);
      slow_addr = '1;

      // halt during fetch of addr 2, then single step to DONE
      do_reset();
      last_pc = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_req_at(32'd2);
      halt_req = 1'b1;
      wait_commit();
      @(posedge clk);
      #1;
      halt_req = 1'b0;
      chk("halt_state", state, 3);
      chk("halt_pc", pc, 3);
      chk("halt_retired", retired, 3);
      repeat (4) @(posedge clk);
      #1;
      chk("halt_holds", state, 3);
      chk("halt_no_commit", n_commits, 3);
      step_req = 1'b1;
      @(posedge clk);
      #1;
      step_req = 1'b0;
      cyc = 0;
      while (!done && cyc < 50) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      chk("step_done", done, 1);
      chk("step_retired", retired, 4);
      chk("step_pc", pc, 3);
      chk("step_commits", n_commits, 4);

      // start+step together acts as step; then step; then free run
      do_reset();
      last_pc = 32'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_req_at(32'd1);
      halt_req = 1'b1;
      wait_commit();
      @(posedge clk);
      #1;
      halt_req = 1'b0;
      chk("h2_state", state, 3);
      chk("h2_pc", pc, 2);
      start    = 1'b1;
      step_req = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      step_req = 1'b0;
      chk("both_fetch", state, 1);
      wait_halted();
      chk("both_pc", pc, 3);
      chk("both_retired", retired, 3);
      chk("both_commits", n_commits, 3);
      step_req = 1'b1;
      @(posedge clk);
      #1;
      step_req = 1'b0;
      wait_halted();
      chk("step2_pc", pc, 4);
      chk("step2_retired", retired, 4);
      run_to_done(cyc);
      chk("resume_retired", retired, 6);
      chk("resume_pc", pc, 5);
      chk("resume_commits", n_commits, 6);

      // reset mid-fetch at addr 5, stale ack the next cycle
      do_reset();
      last_pc   = 32'd10;
      slow_addr = 32'd5;
      slow_lat  = 50;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_req_at(32'd5);
      mem_en   = 1'b0;
      imem_ack = 1'b0;
      rst      = 1'b1;
      saved    = n_commits;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
      imem_ack = 1'b0;
      chk("mrst_state", state, 0);
      chk("mrst_pc", pc, 0);
      chk("mrst_instr", instr, 0);
      chk("mrst_retired", retired, 0);
      chk("mrst_req", imem_req, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("mrst_no_commit", n_commits, saved);
      chk("mrst_state_hold", state, 0);
      slow_addr = '1;

      // memory never acks
      do_reset();
      mem_en   = 1'b0;
      imem_ack = 1'b0;
      last_pc  = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
`ifdef FETCH_SEQ_TIMEOUT_EN
      repeat (3) @(posedge clk);
      #1;
      chk("tmo_still_fetch", state, 1);
      chk("tmo_err_low", err, 0);
      @(posedge clk);
      #1;
      chk("tmo_state", state, 5);
      chk("tmo_err", err, 1);
      chk("tmo_req", imem_req, 0);
      chk("tmo_pc", pc, 0);
      start    = 1'b1;
      step_req = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      start    = 1'b0;
      step_req = 1'b0;
      chk("tmo_sticky", state, 5);
      chk("tmo_no_commit", n_commits, 0);
      do_reset();
      chk("tmo_rst_state", state, 0);
      chk("tmo_rst_err", err, 0);
`else
      repeat (20) @(posedge clk);
      #1;
      chk("nowd_fetch", state, 1);
      chk("nowd_req", imem_req, 1);
      chk("nowd_err", err, 0);
      do_reset();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got hang expected finish");
      $fatal(1, "global timeout");
   end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Multi-cycle fetch/commit sequencer for the single-issue CPU core.
- Owns the PC and issues instruction fetches to an instruction memory with variable latency (req/ack handshake).
- Gives the core one instruction per commit pulse, which gates the register-file write enable.
- Adds run, halt and single-step control, and stops at a programmed last PC.

Parameters:
- ADDR_W, 32, width of PC and instruction address.
- RESET_PC, 0, PC loaded on reset and on restart from DONE.
- TIMEOUT_CYC, 255, fetch watchdog limit in cycles (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin or resume free-running execution.
- halt_req  in  1  request stop after the current commit.
- step_req  in  1  execute exactly one instruction from HALTED.
- last_pc  in  ADDR_W  address of the final instruction in the stream.
- imem_req  out  1  fetch request; held high until ack.
- imem_addr  out  ADDR_W  fetch address, equal to pc while imem_req is high.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- instr  out  32  registered instruction presented to the core.
- instr_valid  out  1  one-cycle commit strobe; core ANDs it into rf_we.
- pc  out  ADDR_W  PC of instr.
- retired  out  32  count of committed instructions.
- state  out  3  encoded FSM state, for debug.
- done  out  1  high in DONE.
- err  out  1  high in ERROR; constant 0 without FETCH_TIMEOUT_EN.

Behaviour:
- Reset values: state=IDLE; pc=RESET_PC; instr=0; retired=0; imem_req=0; instr_valid=0; done=0; err=0.
- Reset takes effect at the next edge from any state, including mid-fetch. An ack arriving after reset is ignored.
- FSM states: IDLE=0, FETCH=1, EXEC=2, HALTED=3, DONE=4, ERROR=5.
- IDLE:
  - start -> FETCH.
  - halt_req and step_req ignored.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - imem_ack -> capture imem_rdata into instr, go to EXEC.
  - An ack in the same cycle the request is raised is legal. Minimum latency: request edge to instr_valid is 1 cycle.
- EXEC:
  - instr_valid=1 for exactly this cycle; retired increments, wrapping 0xFFFFFFFF -> 0.
  - Next state, in priority order:
    - pc==last_pc -> DONE; pc holds.
    - else if halt_req or step mode -> HALTED; pc <= pc+1.
    - else -> FETCH; pc <= pc+1.
  - pc+1 wraps modulo 2^ADDR_W.
- HALTED:
  - step_req -> FETCH with step mode set.
  - start (without step_req) -> FETCH with step mode cleared.
  - Both start and step_req in the same cycle -> step wins.
- DONE:
  - done=1.
  - start -> pc <= RESET_PC, retired <= 0, go to FETCH.
- Step mode flag:
  - Set only on HALTED + step_req; cleared on any start that is accepted.
  - A single step yields exactly one instr_valid pulse, then returns to HALTED.
- halt_req:
  - Sampled only in EXEC. Asserting it in FETCH does not abort the fetch; the halt takes effect at the following EXEC.
  - Level-sensitive: held high, it stops at every commit.
- start while in FETCH or EXEC is ignored.
- Throughput: 2 cycles per instruction with zero-wait memory.
- When last_pc == RESET_PC, exactly one instruction executes before DONE.

Optional Feature:
- Macro: FETCH_SEQ_TIMEOUT_EN.
- Defined:
  - An 8..32-bit watchdog counter (sized from TIMEOUT_CYC) clears on entering FETCH and increments each FETCH cycle without ack.
  - Reaching TIMEOUT_CYC -> ERROR: imem_req=0, err=1, pc frozen, instr_valid never asserted.
  - ERROR exits only via rst.
- Not defined:
  - No counter; FETCH waits indefinitely; ERROR is unreachable; err is tied 0.

Decomposition:
- Shared package fetch_seq_pkg holds:
  - state encoding localparams (S_IDLE..S_ERROR, width 3);
  - the default RESET_PC constant;
  - the instruction width constant 32.
- One natural sub-module: fetch_seq_wdog, the timeout counter, instantiated only under the macro.
- PC, retire counter and FSM stay in the top module.

Test Plan:
- Zero-wait memory, RESET_PC=0, last_pc=3, start pulse:
  - imem_addr sequence 0,1,2,3;
  - 4 instr_valid pulses, 2 cycles apart;
  - done=1, retired=4, pc=3.
- Ack delayed 5 cycles on fetch of addr 1:
  - imem_req held with imem_addr=1 for 6 cycles;
  - exactly one instr_valid per instruction;
  - instr matches imem_rdata at ack.
- halt_req raised during fetch of addr 2:
  - commit of addr 2, then HALTED with pc=3, retired=3;
  - step_req -> exactly one commit at addr 3 -> DONE;
  - start and step_req together in HALTED -> step behaviour.
- rst asserted while imem_req=1 at addr 5, ack arrives the next cycle:
  - state=IDLE, pc=0, instr_valid stays 0, retired=0.
- last_pc=RESET_PC:
  - single commit then DONE;
  - start in DONE restarts at RESET_PC with retired cleared.
- FETCH_SEQ_TIMEOUT_EN, TIMEOUT_CYC=4, ack never returned:
  - err=1 after 4 FETCH cycles, imem_req=0;
  - stays in ERROR until rst.
